// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB wins, buffered mult/div results drain otherwise; pending-write scoreboard.
// Latency: rf_* registered one cycle after the winning request; hazard_stall is combinational.
// Backpressure: md_ready low while the result buffer is full; wb_stall_req asks WB for a bubble once a result starves.
module rf_wr_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_dat = mem[rd_ptr];

    // Caller gates push on count<DEPTH and pop on count>0.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wrap_inc(wr_ptr);
            if (pop_rdy)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(push_vld) - CW'(pop_rdy);
        end
    end
endmodule

// Shares the single register-file write port between WB and the mult/div result buffer.
// Latency: rf_* registered, 1 cycle; buf_count/wb_stall_req registered; hazard_stall/md_ready combinational.
// Backpressure: md_ready on count only (full buffer refuses even on a same-cycle pop); wb_stall_req after STARVE_MAX denials.
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_dest,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  rd_rs,
    input  logic [4:0]  rd_rt,
    input  logic [4:0]  rd_rd,
    input  logic        rd_we,
    output logic        hazard_stall,
    output logic        wb_stall_req,
    output logic        rf_regwrite,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic [2:0]  buf_count
);
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] dat;
    } md_ent_t;

    md_ent_t     push_ent, head;
    logic        wb_req, buf_nonempty, pop, push;
    logic [31:0] pending, pending_nxt;
    logic [3:0]  starve_cnt, starve_nxt;

    assign wb_req       = wb_we & (wb_reg != 5'd0);
    assign buf_nonempty = (buf_count != 3'd0);
    assign pop          = buf_nonempty & ~wb_req;
    assign md_ready     = rst & (buf_count < 3'(DEPTH));
    // Results for r0 are acknowledged but never stored.
    assign push         = md_valid & md_ready & (md_reg != 5'd0);
    assign push_ent     = '{dest: md_reg, dat: md_data};

    rf_wr_fifo #(
        .W     ($bits(md_ent_t)),
        .DEPTH (DEPTH),
        .CW    (3)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (push_ent),
        .pop_rdy  (pop),
        .pop_dat  (head),
        .count    (buf_count)
    );

    // Issue is applied after the pop clear so a same-register set wins.
    always_comb begin
        pending_nxt = pending;
        if (pop)      pending_nxt[head.dest] = 1'b0;
        if (md_issue) pending_nxt[md_dest]   = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || !buf_nonempty)
            starve_nxt = '0;
        else if (starve_cnt != 4'(STARVE_MAX))
            starve_nxt = starve_cnt + 4'd1;
    end

    assign hazard_stall = pending[rd_rs] | pending[rd_rt] | (rd_we & pending[rd_rd]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_regwrite   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            pending       <= '0;
            starve_cnt    <= '0;
            wb_stall_req  <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            starve_cnt   <= starve_nxt;
            wb_stall_req <= (starve_nxt == 4'(STARVE_MAX));
            if (wb_req) begin
                rf_regwrite   <= 1'b1;
                rf_write_reg  <= wb_reg;
                rf_write_data <= wb_data;
            end else if (pop) begin
                rf_regwrite   <= 1'b1;
                rf_write_reg  <= head.dest;
                rf_write_data <= head.dat;
            end else begin
                rf_regwrite   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (DEPTH=2, STARVE_MAX=4): vector table plus hand sequences.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we, md_issue, md_valid, rd_we;
    logic [4:0]  wb_reg, md_dest, md_reg, rd_rs, rd_rt, rd_rd;
    logic [31:0] wb_data, md_data;
    logic        md_ready, hazard_stall, wb_stall_req, rf_regwrite;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [2:0]  buf_count;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_issue(md_issue), .md_dest(md_dest),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .rd_rs(rd_rs), .rd_rt(rd_rt), .rd_rd(rd_rd), .rd_we(rd_we),
        .hazard_stall(hazard_stall), .wb_stall_req(wb_stall_req),
        .rf_regwrite(rf_regwrite), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .buf_count(buf_count)
    );

    typedef struct {
        logic        rst;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        md_issue;
        logic [4:0]  md_dest;
        logic        md_valid;
        logic [4:0]  md_reg;
        logic [31:0] md_data;
        logic [4:0]  rs, rt, rd;
        logic        rdwe;
        logic        e_hz, e_rdy;
        logic        e_we, e_ck;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_stall;
    } vec_t;

    int checks = 0;
    int failures = 0;
    vec_t vt[$];

    function automatic vec_t mk(
        input logic r, input logic wwe, input logic [4:0] wreg, input logic [31:0] wdat,
        input logic iss, input logic [4:0] idest,
        input logic mv, input logic [4:0] mreg, input logic [31:0] mdat,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic dwe,
        input logic ehz, input logic erdy,
        input logic ewe, input logic eck, input logic [4:0] ereg, input logic [31:0] edat,
        input logic [2:0] ecnt, input logic estall);
        vec_t v;
        v.rst = r; v.wb_we = wwe; v.wb_reg = wreg; v.wb_data = wdat;
        v.md_issue = iss; v.md_dest = idest;
        v.md_valid = mv; v.md_reg = mreg; v.md_data = mdat;
        v.rs = s; v.rt = t; v.rd = d; v.rdwe = dwe;
        v.e_hz = ehz; v.e_rdy = erdy;
        v.e_we = ewe; v.e_ck = eck; v.e_reg = ereg; v.e_data = edat;
        v.e_cnt = ecnt; v.e_stall = estall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b1; wb_we = 1'b0; wb_reg = '0; wb_data = '0;
        md_issue = 1'b0; md_dest = '0; md_valid = 1'b0; md_reg = '0; md_data = '0;
        rd_rs = '0; rd_rt = '0; rd_rd = '0; rd_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst = 1'b0;
        step();

        // Reset held with live requests
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0,1,3,32'h99, 1,6, 1,4,32'h5, 6,0,0,0, 0,0, 0,1,0,32'h0,0,0));
        // WB priority over a buffered result
        vt.push_back(mk(1,0,0,32'h0, 0,0, 1,7,32'h11, 0,0,0,0, 0,1, 0,0,0,32'h0,1,0));
        vt.push_back(mk(1,1,5,32'hAAAA0000, 0,0, 0,0,32'h0, 0,0,0,0, 0,1, 1,1,5,32'hAAAA0000,1,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,0,0, 0,1, 1,1,7,32'h11,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,0,0, 0,1, 0,1,7,32'h11,0,0));
        // Scoreboard set, hit, clear by pop
        vt.push_back(mk(1,0,0,32'h0, 1,9, 0,0,32'h0, 9,0,0,0, 0,1, 0,0,0,32'h0,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 9,0,0,0, 1,1, 0,0,0,32'h0,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 1,9,32'h1234, 9,0,0,0, 1,1, 0,0,0,32'h0,1,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 9,0,0,0, 1,1, 1,1,9,32'h1234,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 9,0,0,0, 0,1, 0,0,0,32'h0,0,0));
        // rd term, WB does not clear pending, r0 requests ignored
        vt.push_back(mk(1,0,0,32'h0, 1,12, 0,0,32'h0, 0,0,0,0, 0,1, 0,0,0,32'h0,0,0));
        vt.push_back(mk(1,1,12,32'h77, 0,0, 0,0,32'h0, 0,0,12,0, 0,1, 1,1,12,32'h77,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,12,1, 1,1, 0,0,0,32'h0,0,0));
        vt.push_back(mk(1,1,0,32'hDEAD, 0,0, 1,0,32'hBEEF, 0,0,0,0, 0,1, 0,1,12,32'h77,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 1,12,32'hC0FFEE, 0,0,12,1, 1,1, 0,0,0,32'h0,1,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,12,1, 1,1, 1,1,12,32'hC0FFEE,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,12,1, 0,1, 0,0,0,32'h0,0,0));
        vt.push_back(mk(1,0,0,32'h0, 1,0, 0,0,32'h0, 0,0,0,0, 0,1, 0,0,0,32'h0,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,0,1, 0,1, 0,0,0,32'h0,0,0));
        // Full buffer under continuous WB, then in-order drain across the pointer wrap
        vt.push_back(mk(1,1,1,32'h101, 0,0, 1,20,32'hA0, 0,0,0,0, 0,1, 1,1,1,32'h101,1,0));
        vt.push_back(mk(1,1,2,32'h102, 0,0, 1,21,32'hA1, 0,0,0,0, 0,1, 1,1,2,32'h102,2,0));
        vt.push_back(mk(1,1,3,32'h103, 0,0, 1,22,32'hA2, 0,0,0,0, 0,0, 1,1,3,32'h103,2,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 1,22,32'hA2, 0,0,0,0, 0,0, 1,1,20,32'hA0,1,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 1,22,32'hA2, 0,0,0,0, 0,1, 1,1,21,32'hA1,1,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,0,0, 0,1, 1,1,22,32'hA2,0,0));
        vt.push_back(mk(1,0,0,32'h0, 0,0, 0,0,32'h0, 0,0,0,0, 0,1, 0,1,22,32'hA2,0,0));

        foreach (vt[i]) begin
            rst = vt[i].rst; wb_we = vt[i].wb_we; wb_reg = vt[i].wb_reg; wb_data = vt[i].wb_data;
            md_issue = vt[i].md_issue; md_dest = vt[i].md_dest;
            md_valid = vt[i].md_valid; md_reg = vt[i].md_reg; md_data = vt[i].md_data;
            rd_rs = vt[i].rs; rd_rt = vt[i].rt; rd_rd = vt[i].rd; rd_we = vt[i].rdwe;
            #1;
            chk($sformatf("v%0d.hazard_stall", i), hazard_stall, vt[i].e_hz);
            chk($sformatf("v%0d.md_ready", i), md_ready, vt[i].e_rdy);
            step();
            chk($sformatf("v%0d.rf_regwrite", i), rf_regwrite, vt[i].e_we);
            if (vt[i].e_ck) begin
                chk($sformatf("v%0d.rf_write_reg", i), rf_write_reg, vt[i].e_reg);
                chk($sformatf("v%0d.rf_write_data", i), rf_write_data, vt[i].e_data);
            end
            chk($sformatf("v%0d.buf_count", i), buf_count, vt[i].e_cnt);
            chk($sformatf("v%0d.wb_stall_req", i), wb_stall_req, vt[i].e_stall);
        end

        // Starvation: one entry denied by WB every cycle, counter saturates
        set_idle();
        md_valid = 1'b1; md_reg = 5'd15; md_data = 32'h5A;
        step();
        chk("starve.buf_count", buf_count, 3'd1);
        md_valid = 1'b0; wb_we = 1'b1; wb_reg = 5'd2; wb_data = 32'h2;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("starve.denied%0d", k), wb_stall_req, (k >= 4));
        end
        wb_we = 1'b0;
        step();
        chk("starve.pop_we", rf_regwrite, 1'b1);
        chk("starve.pop_reg", rf_write_reg, 5'd15);
        chk("starve.pop_data", rf_write_data, 32'h5A);
        chk("starve.released", wb_stall_req, 1'b0);
        chk("starve.empty", buf_count, 3'd0);

        // Pop of r3 on the same edge as a new issue to r3
        set_idle();
        md_issue = 1'b1; md_dest = 5'd3;
        step();
        md_issue = 1'b0; md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h33;
        step();
        md_valid = 1'b0; md_issue = 1'b1; md_dest = 5'd3;
        step();
        chk("setclr.pop_reg", rf_write_reg, 5'd3);
        chk("setclr.pop_data", rf_write_data, 32'h33);
        md_issue = 1'b0; rd_rt = 5'd3;
        #1;
        chk("setclr.still_pending", hazard_stall, 1'b1);
        md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h34;
        step();
        md_valid = 1'b0;
        step();
        chk("setclr.second_data", rf_write_data, 32'h34);
        #1;
        chk("setclr.cleared", hazard_stall, 1'b0);

        // Reset mid-operation drops the buffered entry and the pending bit
        set_idle();
        md_issue = 1'b1; md_dest = 5'd8;
        step();
        md_issue = 1'b0; wb_we = 1'b1; wb_reg = 5'd1; wb_data = 32'h1;
        md_valid = 1'b1; md_reg = 5'd8; md_data = 32'h88;
        step();
        chk("midrst.buffered", buf_count, 3'd1);
        wb_we = 1'b0; md_valid = 1'b0; rst = 1'b0;
        #1;
        chk("midrst.md_ready", md_ready, 1'b0);
        step();
        chk("midrst.rf_regwrite", rf_regwrite, 1'b0);
        chk("midrst.rf_write_reg", rf_write_reg, 5'd0);
        chk("midrst.buf_count", buf_count, 3'd0);
        rst = 1'b1; rd_rs = 5'd8;
        #1;
        chk("midrst.no_hazard", hazard_stall, 1'b0);
        chk("midrst.md_ready_back", md_ready, 1'b1);
        step();
        chk("midrst.nothing_drained", rf_regwrite, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
